// File: rtl/bypass_network.sv
// Forwarding/hazard unit: scoreboard of in-flight register writes across the post-decode stages,
// resolving each source operand to the youngest ready result or stalling decode on an unready one.
module bypass_network #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned NREAD  = 2,
    localparam int unsigned AW = $clog2(NREG),
    localparam int unsigned LW = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   adv,
    input  logic [STAGES-1:0]      kill,
    input  logic                   issue_valid,
    input  logic                   issue_wen,
    input  logic [AW-1:0]          issue_waddr,
    input  logic [LW-1:0]          issue_lat,
    input  logic [NREAD-1:0]       rd_en,
    input  logic [NREAD*AW-1:0]    rd_addr,
    input  logic [NREAD*XLEN-1:0]  rd_rf_data,
    input  logic [STAGES*XLEN-1:0] stg_data,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_fwd,
    output logic                   stall,
    output logic [LW-1:0]          inflight
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [AW-1:0]     waddr [STAGES];
    logic [LW-1:0]     lat   [STAGES];
    logic [LW-1:0]     lat_in;
    logic [LW-1:0]     cnt_next;
    logic              lk_hit;
    logic              lk_rdy;
    logic [XLEN-1:0]   lk_val;

    // Out-of-range latency is clamped to the last stage so the entry still resolves eventually.
    assign lat_in = (issue_lat >= LW'(STAGES)) ? LW'(STAGES - 1) : issue_lat;

    // Operand lookup: scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        rd_data = rd_rf_data;
        rd_fwd  = '0;
        stall   = 1'b0;
        lk_hit  = 1'b0;
        lk_rdy  = 1'b0;
        lk_val  = '0;
        for (int p = 0; p < int'(NREAD); p++) begin
            lk_hit = 1'b0;
            lk_rdy = 1'b0;
            lk_val = '0;
            for (int s = int'(STAGES) - 1; s >= 0; s--) begin
                if (rd_en[p] && v[s] && (waddr[s] == rd_addr[p*AW +: AW]) &&
                    (rd_addr[p*AW +: AW] != '0)) begin
                    lk_hit = 1'b1;
                    lk_rdy = (s >= int'(lat[s]));
                    lk_val = stg_data[s*XLEN +: XLEN];
                end
            end
            if (lk_hit && lk_rdy) begin
                rd_data[p*XLEN +: XLEN] = lk_val;
                rd_fwd[p]               = 1'b1;
            end else if (lk_hit) begin
                stall = 1'b1;
            end
        end
    end

    // Next valid vector: kills apply before the shift; a stalled issue becomes a bubble.
    always_comb begin
        v_next = v & ~kill;
        if (adv) begin
            for (int s = 1; s < int'(STAGES); s++) begin
                v_next[s] = v[s-1] & ~kill[s-1];
            end
            v_next[0] = issue_valid & issue_wen & (issue_waddr != '0) & ~stall;
        end
        cnt_next = '0;
        for (int s = 0; s < int'(STAGES); s++) begin
            cnt_next = cnt_next + LW'(v_next[s]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v        <= '0;
            inflight <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                waddr[s] <= '0;
                lat[s]   <= '0;
            end
        end else begin
            v        <= v_next;
            inflight <= cnt_next;
            if (adv) begin
                for (int s = 1; s < int'(STAGES); s++) begin
                    waddr[s] <= waddr[s-1];
                    lat[s]   <= lat[s-1];
                end
                waddr[0] <= issue_waddr;
                lat[0]   <= lat_in;
            end
        end
    end

    illegal_lat: assert property (@(posedge clk) disable iff (!reset)
        (adv && issue_valid && issue_wen) |-> (issue_lat < LW'(STAGES)));

endmodule
